job_launcher: RTL and testbench

Initiator side of the go/kill/done worker handshake. Accepts job requests on a valid/ready port and pulses `go` to one worker. It supervises the run with a timeout watchdog, kills and retries hung runs, and returns one response per request with a pass/fail status. It sits between the job scheduler and a single worker FSM, and shares that worker's clock and reset.

---
 rtl/job_launcher_pkg.sv | 34 +++
 rtl/jl_watchdog.sv | 28 ++
 rtl/job_launcher.sv | 147 ++++++++++++++
 tb/tb_job_launcher.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/job_launcher_pkg.sv
// Shared types and defaults for the job launcher: FSM states, response status values
// and parameter defaults.
package job_launcher_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StKill,
    StCool,
    StResp
  } jl_state_t;

  localparam logic RSP_STATUS_OK   = 1'b1;
  localparam logic RSP_STATUS_FAIL = 1'b0;

  localparam int unsigned TIMEOUT_DEF   = 128;
  localparam int unsigned KILL_HOLD_DEF = 4;
  localparam int unsigned MAX_RETRY_DEF = 2;
  localparam int unsigned CNT_W_DEF     = 8;

  // Nominal worker latency from the go edge to done.
  localparam int unsigned DONE_LATENCY_NOM = 103;

  // One timer serves both the WAIT timeout and the KILL hold, so it must fit the larger limit.
  function automatic int unsigned jl_timer_width(input int unsigned timeout,
                                                 input int unsigned kill_hold);
    int unsigned span;
    span = (timeout > kill_hold) ? timeout : kill_hold;
    if (span < 2) span = 2;
    return int'($clog2(span));
  endfunction

endpackage

// File: rtl/jl_watchdog.sv
// Clearable up-counter that flags when it reaches a programmable limit; clear wins over
// enable so the count is reset before it can pass the limit.
module jl_watchdog #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == limit);

endmodule

// File: rtl/job_launcher.sv
// Initiator side of the go/kill/done worker handshake: launches one job at a time,
// supervises it with a watchdog, kills and retries hung runs, and reports a status.
module job_launcher
  import job_launcher_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned KILL_HOLD = KILL_HOLD_DEF,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             abort_req,
  output logic             go,
  output logic             kill,
  input  logic             done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [3:0]       rsp_retries,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] abort_count,
  output logic             busy
);

  localparam int unsigned TimerW = jl_timer_width(TIMEOUT, KILL_HOLD);
  localparam logic [TimerW-1:0] WaitLimit = TimerW'(TIMEOUT - 1);
  localparam logic [TimerW-1:0] KillLimit = TimerW'(KILL_HOLD - 1);
  localparam logic [3:0]        MaxRetry  = 4'(MAX_RETRY);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  jl_state_t        state_q;
  logic             go_q, kill_q, rsp_valid_q, rsp_ok_q, final_fail_q;
  logic [3:0]       retries_q;
  logic [CNT_W-1:0] ok_count_q, abort_count_q;

  logic              in_wait, in_kill, wait_exit;
  logic              timer_clear, timer_enable, timer_expire;
  logic [TimerW-1:0] timer_limit;

  // The timer only runs in WAIT and KILL and restarts whenever either phase is left.
  always_comb begin
    in_wait      = (state_q == StWait);
    in_kill      = (state_q == StKill);
    wait_exit    = in_wait & (done | abort_req | timer_expire);
    timer_enable = in_wait | in_kill;
    timer_clear  = ~timer_enable | wait_exit | (in_kill & timer_expire);
    timer_limit  = in_kill ? KillLimit : WaitLimit;
  end

  jl_watchdog #(
    .WIDTH(TimerW)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_enable),
    .limit (timer_limit),
    .expire(timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      go_q          <= 1'b0;
      kill_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_ok_q      <= RSP_STATUS_FAIL;
      final_fail_q  <= 1'b0;
      retries_q     <= '0;
      ok_count_q    <= '0;
      abort_count_q <= '0;
    end else begin
      go_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q      <= StLaunch;
            go_q         <= 1'b1;
            retries_q    <= '0;
            final_fail_q <= 1'b0;
          end
        end
        StLaunch: begin
          state_q <= StWait;
        end
        StWait: begin
          if (done) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_ok_q    <= RSP_STATUS_OK;
          end else if (abort_req) begin
            state_q      <= StKill;
            kill_q       <= 1'b1;
            final_fail_q <= 1'b1;
          end else if (timer_expire) begin
            state_q      <= StKill;
            kill_q       <= 1'b1;
            final_fail_q <= (retries_q == MaxRetry);
          end
        end
        StKill: begin
          if (timer_expire) begin
            state_q <= StCool;
            kill_q  <= 1'b0;
          end
        end
        StCool: begin
          if (final_fail_q) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_ok_q    <= RSP_STATUS_FAIL;
          end else begin
            state_q   <= StLaunch;
            go_q      <= 1'b1;
            retries_q <= retries_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            if (rsp_ok_q == RSP_STATUS_OK) begin
              if (ok_count_q != CntMax) ok_count_q <= ok_count_q + 1'b1;
            end else begin
              if (abort_count_q != CntMax) abort_count_q <= abort_count_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle) & ~reset;
  assign busy        = (state_q != StIdle);
  assign go          = go_q;
  assign kill        = kill_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_retries = retries_q;
  assign ok_count    = ok_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_job_launcher.sv
// Bench for job_launcher: worker model plus a timeline model of each job, random and
// directed scenarios, and a narrow-counter instance for saturation.
module tb_job_launcher;
  import job_launcher_pkg::*;

  localparam int TO = int'(TIMEOUT_DEF);
  localparam int KH = int'(KILL_HOLD_DEF);
  localparam int MR = int'(MAX_RETRY_DEF);
  localparam int CW = int'(CNT_W_DEF);
  localparam int SW = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, abort_req = 1'b0, rsp_ready = 1'b1;
  logic worker_done = 1'b0, stray_done = 1'b0, done;
  logic req_ready, go, kill, rsp_valid, rsp_ok, busy;
  logic [3:0] rsp_retries;
  logic [CW-1:0] ok_count, abort_count;
  logic s_req_ready, s_go, s_kill, s_rsp_valid, s_rsp_ok, s_busy;
  logic [3:0] s_rsp_retries;
  logic [SW-1:0] s_ok_count, s_abort_count;

  assign done = worker_done | stray_done;
  always #5 clk = ~clk;

  job_launcher dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .abort_req(abort_req), .go(go), .kill(kill), .done(done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_ok(rsp_ok), .rsp_retries(rsp_retries), .ok_count(ok_count),
    .abort_count(abort_count), .busy(busy)
  );

  job_launcher #(.CNT_W(SW)) dut_s (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
    .abort_req(abort_req), .go(s_go), .kill(s_kill), .done(done), .rsp_valid(s_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_ok(s_rsp_ok), .rsp_retries(s_rsp_retries),
    .ok_count(s_ok_count), .abort_count(s_abort_count), .busy(s_busy)
  );

  typedef struct {int rsp_cyc; bit ok; int retries; int gos; int kill_cyc; int bursts;} exp_t;
  typedef struct {
    int rsp_cyc; bit ok; int retries; int gos; int kill_cyc; int bursts;
    bit accepted; bit go_first; bit stable; bit timed_out;
    bit after_valid; bit after_ready; bit after_busy;
  } obs_t;

  int checks = 0, failures = 0;
  int exp_ok = 0, exp_ab = 0;
  int job_lat[$];
  int wq[$];
  int wcnt = 0;

  // Worker: each go takes the next latency from wq (0 = hang); kill or reset cancels the run.
  always @(negedge clk) begin
    worker_done = 1'b0;
    if (reset || kill) begin
      wcnt = 0;
      if (reset) wq.delete();
    end else begin
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) worker_done = 1'b1;
      end
      if (go) wcnt = (wq.size() > 0) ? wq.pop_front() : 0;
    end
  end

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Cycle 1 is the first cycle after the accepting edge; walks each attempt's WAIT cycles
  // applying done > abort > timeout, with failed attempts costing launch+wait+kill+cool.
  function automatic exp_t model_job(input int lat[$], input int ab_s, input int ab_e);
    exp_t e;
    int s, l, next_s;
    e = '{default: 0};
    s = 1;
    for (int a = 0; a <= MR; a++) begin
      l = (a < lat.size()) ? lat[a] : 0;
      next_s = s;
      e.gos++;
      for (int w = s + 1; w <= s + TO; w++) begin
        if (l > 0 && w == s + l) begin
          e.ok = 1'b1; e.retries = a; e.rsp_cyc = w + 1;
          return e;
        end
        if (w >= ab_s && w <= ab_e) begin
          e.bursts++; e.kill_cyc += KH; e.retries = a; e.rsp_cyc = w + KH + 2;
          return e;
        end
        if (w == s + TO) begin
          e.bursts++; e.kill_cyc += KH;
          if (a == MR) begin
            e.retries = a; e.rsp_cyc = w + KH + 2;
            return e;
          end
          next_s = w + KH + 2;
        end
      end
      s = next_s;
    end
    return e;
  endfunction

  function automatic void account(input exp_t e);
    if (e.ok) exp_ok++;
    else exp_ab++;
  endfunction

  // Entered just after a negedge with the DUT idle; returns just after the negedge following
  // the response handshake.
  task automatic drive_job(input int ab_s, input int ab_e, input int rsp_delay, output obs_t o);
    int cyc;
    bit prev_kill;
    o = '{default: 0};
    wq = job_lat;
    rsp_ready = (rsp_delay == 0);
    o.accepted = req_ready;
    req_valid = 1'b1;
    cyc = 0;
    prev_kill = 1'b0;
    o.timed_out = 1'b1;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (cyc == 1) o.go_first = go;
      if (go) o.gos++;
      if (kill) begin
        o.kill_cyc++;
        if (!prev_kill) o.bursts++;
      end
      prev_kill = kill;
      if (rsp_valid) begin
        o.timed_out = 1'b0;
        break;
      end
      abort_req = (cyc >= ab_s && cyc <= ab_e);
    end
    abort_req = 1'b0;
    o.rsp_cyc = cyc;
    o.ok = rsp_ok;
    o.retries = int'(rsp_retries);
    o.stable = 1'b1;
    if (!o.timed_out) begin
      for (int k = 0; k < rsp_delay; k++) begin
        @(negedge clk);
        if (!(rsp_valid && rsp_ok == o.ok && int'(rsp_retries) == o.retries && !req_ready
              && busy)) o.stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      o.after_valid = rsp_valid;
      o.after_ready = req_ready;
      o.after_busy = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++;
    if ({go, kill, rsp_valid, rsp_ok, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got=%b want=00000", {go, kill, rsp_valid, rsp_ok, busy});
    end
    checks++;
    if (ok_count !== '0 || abort_count !== '0 || rsp_retries !== 4'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", ok_count, abort_count, rsp_retries);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready got=%b want=1", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_nominal();
    obs_t o; exp_t e;
    job_lat = '{int'(DONE_LATENCY_NOM)};
    e = model_job(job_lat, 0, -1);
    drive_job(0, -1, 0, o);
    account(e);
    checks++;
    if (!o.accepted || o.timed_out) begin failures++; $display("FAIL nominal_handshake acc=%b to=%b want 1/0", o.accepted, o.timed_out); end
    checks++;
    if (o.ok !== e.ok || o.retries != e.retries) begin
      failures++; $display("FAIL nominal_rsp got=%0d/%0d want=%0d/%0d", o.ok, o.retries, e.ok, e.retries);
    end
    checks++;
    if (o.gos != 1 || !o.go_first || o.kill_cyc != 0) begin
      failures++; $display("FAIL nominal_go gos=%0d first=%b kills=%0d want 1/1/0", o.gos, o.go_first, o.kill_cyc);
    end
    checks++;
    if (o.rsp_cyc != e.rsp_cyc) begin failures++; $display("FAIL nominal_latency got=%0d want=%0d", o.rsp_cyc, e.rsp_cyc); end
    checks++;
    if (int'(ok_count) != sat(exp_ok, CW)) begin failures++; $display("FAIL nominal_ok_count got=%0d want=%0d", ok_count, sat(exp_ok, CW)); end
  endtask

  task automatic test_hung();
    obs_t o; exp_t e;
    job_lat = {};
    e = model_job(job_lat, 0, -1);
    drive_job(0, -1, 0, o);
    account(e);
    checks++;
    if (o.ok !== 1'b0 || o.retries != MR) begin failures++; $display("FAIL hung_rsp got=%0d/%0d want=0/%0d", o.ok, o.retries, MR); end
    checks++;
    if (o.gos != e.gos || o.bursts != e.bursts || o.kill_cyc != e.kill_cyc) begin
      failures++; $display("FAIL hung_pulses got=%0d/%0d/%0d want=%0d/%0d/%0d", o.gos, o.bursts, o.kill_cyc, e.gos, e.bursts, e.kill_cyc);
    end
    checks++;
    if (o.rsp_cyc != e.rsp_cyc) begin failures++; $display("FAIL hung_latency got=%0d want=%0d", o.rsp_cyc, e.rsp_cyc); end
    checks++;
    if (int'(abort_count) != sat(exp_ab, CW)) begin failures++; $display("FAIL hung_abort_count got=%0d want=%0d", abort_count, sat(exp_ab, CW)); end
  endtask

  task automatic test_reset_kill();
    bit seen;
    job_lat = {};
    wq = job_lat;
    req_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (kill) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rstkill_reach got=0 want=1"); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({kill, go, busy, rsp_valid, req_ready} !== 5'b0) begin
      failures++; $display("FAIL rstkill_outputs got=%b want=00000", {kill, go, busy, rsp_valid, req_ready});
    end
    checks++;
    if (ok_count !== '0 || abort_count !== '0) begin
      failures++; $display("FAIL rstkill_counters got=%0d/%0d want=0/0", ok_count, abort_count);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_ok = 0;
    exp_ab = 0;
    @(negedge clk);
  endtask

  task automatic test_retry_success();
    obs_t o; exp_t e;
    job_lat = '{0, 50};
    e = model_job(job_lat, 0, -1);
    drive_job(0, -1, 0, o);
    account(e);
    checks++;
    if (o.ok !== 1'b1 || o.retries != 1) begin failures++; $display("FAIL retry_rsp got=%0d/%0d want=1/1", o.ok, o.retries); end
    checks++;
    if (o.rsp_cyc != e.rsp_cyc || o.gos != 2 || o.bursts != 1) begin
      failures++; $display("FAIL retry_timing got=%0d/%0d/%0d want=%0d/2/1", o.rsp_cyc, o.gos, o.bursts, e.rsp_cyc);
    end
  endtask

  task automatic test_abort();
    obs_t o; exp_t e;
    job_lat = {};
    e = model_job(job_lat, 12, 400);
    drive_job(12, 400, 0, o);
    account(e);
    checks++;
    if (o.ok !== 1'b0 || o.retries != 0) begin failures++; $display("FAIL abort_rsp got=%0d/%0d want=0/0", o.ok, o.retries); end
    checks++;
    if (o.gos != 1 || o.bursts != 1 || o.kill_cyc != KH || o.rsp_cyc != e.rsp_cyc) begin
      failures++; $display("FAIL abort_seq got=%0d/%0d/%0d/%0d want=1/1/%0d/%0d", o.gos, o.bursts, o.kill_cyc, o.rsp_cyc, KH, e.rsp_cyc);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o; exp_t e;
    job_lat = '{TO};
    e = model_job(job_lat, 1 + TO, 1 + TO);
    drive_job(1 + TO, 1 + TO, 0, o);
    account(e);
    checks++;
    if (o.ok !== 1'b1 || o.kill_cyc != 0 || o.rsp_cyc != e.rsp_cyc) begin
      failures++; $display("FAIL simul_rsp got=%0d/%0d/%0d want=1/0/%0d", o.ok, o.kill_cyc, o.rsp_cyc, e.rsp_cyc);
    end
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || go !== 1'b0) begin
      failures++; $display("FAIL stray_done_state busy=%b ready=%b go=%b want 0/1/0", busy, req_ready, go);
    end
    checks++;
    if (int'(ok_count) != sat(exp_ok, CW) || int'(abort_count) != sat(exp_ab, CW)) begin
      failures++; $display("FAIL stray_done_counts got=%0d/%0d want=%0d/%0d", ok_count, abort_count, sat(exp_ok, CW), sat(exp_ab, CW));
    end
  endtask

  task automatic test_abort_in_retry_kill();
    obs_t o; exp_t e;
    job_lat = '{0, 30};
    e = model_job(job_lat, TO + 2, TO + KH + 2);
    drive_job(TO + 2, TO + KH + 2, 0, o);
    account(e);
    checks++;
    if (o.ok !== e.ok || o.retries != e.retries || o.rsp_cyc != e.rsp_cyc) begin
      failures++; $display("FAIL abort_in_kill got=%0d/%0d/%0d want=%0d/%0d/%0d", o.ok, o.retries, o.rsp_cyc, e.ok, e.retries, e.rsp_cyc);
    end
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e;
    job_lat = '{20};
    e = model_job(job_lat, 0, -1);
    drive_job(0, -1, 20, o);
    account(e);
    checks++;
    if (!o.stable) begin failures++; $display("FAIL bp_stable got=0 want=1"); end
    checks++;
    if (o.after_valid !== 1'b0 || o.after_ready !== 1'b1 || o.after_busy !== 1'b0) begin
      failures++; $display("FAIL bp_release got=%b%b%b want=010", o.after_valid, o.after_ready, o.after_busy);
    end
    checks++;
    if (int'(ok_count) != sat(exp_ok, CW)) begin failures++; $display("FAIL bp_ok_count got=%0d want=%0d", ok_count, sat(exp_ok, CW)); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    int nh, ab_s, ab_e, dly;
    for (int j = 0; j < 12; j++) begin
      nh = int'($urandom_range(0, 3));
      job_lat = {};
      for (int a = 0; a < nh; a++) job_lat.push_back(0);
      if (nh <= MR) job_lat.push_back(int'($urandom_range(1, TO)));
      ab_s = 0;
      ab_e = -1;
      if ($urandom_range(0, 3) == 0) begin
        ab_s = int'($urandom_range(1, 300));
        ab_e = ab_s + int'($urandom_range(0, 20));
      end
      dly = int'($urandom_range(0, 3));
      e = model_job(job_lat, ab_s, ab_e);
      drive_job(ab_s, ab_e, dly, o);
      account(e);
      checks++;
      if (o.timed_out || o.ok !== e.ok || o.retries != e.retries || o.rsp_cyc != e.rsp_cyc) begin
        failures++; $display("FAIL rand%0d_rsp got=%0d/%0d/%0d want=%0d/%0d/%0d", j, o.ok, o.retries, o.rsp_cyc, e.ok, e.retries, e.rsp_cyc);
      end
      checks++;
      if (o.gos != e.gos || o.bursts != e.bursts || o.kill_cyc != e.kill_cyc) begin
        failures++; $display("FAIL rand%0d_pulses got=%0d/%0d/%0d want=%0d/%0d/%0d", j, o.gos, o.bursts, o.kill_cyc, e.gos, e.bursts, e.kill_cyc);
      end
      checks++;
      if (int'(ok_count) != sat(exp_ok, CW) || int'(abort_count) != sat(exp_ab, CW)) begin
        failures++; $display("FAIL rand%0d_counts got=%0d/%0d want=%0d/%0d", j, ok_count, abort_count, sat(exp_ok, CW), sat(exp_ab, CW));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    for (int j = 0; j < 5; j++) begin
      job_lat = '{int'($urandom_range(1, 8))};
      e = model_job(job_lat, 0, -1);
      drive_job(0, -1, 0, o);
      account(e);
      checks++;
      if (!o.accepted || o.ok !== 1'b1 || o.rsp_cyc != e.rsp_cyc || o.after_ready !== 1'b1) begin
        failures++; $display("FAIL b2b%0d got acc=%b ok=%0d cyc=%0d rdy=%b want 1/1/%0d/1", j, o.accepted, o.ok, o.rsp_cyc, o.after_ready, e.rsp_cyc);
      end
    end
    checks++;
    if (int'(s_ok_count) != sat(exp_ok, SW) || int'(s_abort_count) != sat(exp_ab, SW)) begin
      failures++; $display("FAIL sat_counts got=%0d/%0d want=%0d/%0d", s_ok_count, s_abort_count, sat(exp_ok, SW), sat(exp_ab, SW));
    end
    checks++;
    if (int'(ok_count) != sat(exp_ok, CW)) begin failures++; $display("FAIL b2b_ok_count got=%0d want=%0d", ok_count, sat(exp_ok, CW)); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hung();
    test_reset_kill();
    test_retry_success();
    test_abort();
    test_simultaneous();
    test_abort_in_retry_kill();
    test_backpressure();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
